aurora_rx_lane: RTL and testbench
=================================

// Module: aurora_rx_lane
// PURPOSE
//  Receive end of the simplex 64B/66B lane: takes 66-bit blocks from the gearbox, does block lock
//  (sync-header hunt with slip request), self-sync descrambling and control-block decode.
//  Emits AXI-stream words with last/keep; no backpressure. One instance per lane.
// PARAMETERS
//  AXI_DATA_SIZE      64  payload/AXI width (fixed 64, bytes 0..7 = bits [7:0]..[63:56])
//  ENCODED_DATA_SIZE  66  block width: [65:64] sync header, [63:0] scrambled payload
//  LOCK_COUNT         64  consecutive valid headers required to declare lock
//  BAD_LIMIT          16  invalid headers within one 64-block window that drop lock
// PORTS
//  clk            in   1    lane clock
//  rst            in   1    asynchronous, active-high reset
//  encoded_valid  in   1    encoded_data holds a block this cycle
//  encoded_data   in   66   received block
//  slip           out  1    1-cycle pulse: gearbox shifts alignment by one bit
//  rx_aligned     out  1    block lock achieved
//  axi_valid      out  1    axi_data/keep/last valid (single-cycle, no ready)
//  axi_last       out  1    final word of frame
//  axi_keep       out  8    valid bytes, contiguous from byte 0
//  axi_data       out  64   descrambled user data
//  frame_err      out  1    1-cycle pulse: frame discarded (bad ctrl type/count, lock loss mid-frame)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, counters 0, held slot empty, descrambler state 0.
//  Header: 2'b01 data, 2'b10 control, 2'b00/2'b11 invalid. Only cycles with encoded_valid=1 count.
//  Lock FSM:
//   HUNT: valid hdr -> good_cnt++; invalid -> good_cnt=0, slip=1 next cycle, then ignore 2 blocks.
//         good_cnt==LOCK_COUNT -> LOCKED, rx_aligned=1 from next cycle.
//   LOCKED: 64-block window counter; invalid hdr -> bad_cnt++. bad_cnt reaching BAD_LIMIT -> HUNT,
//         rx_aligned=0 next cycle, all counters 0. Window wrap (64th block) clears bad_cnt;
//         a bad hdr on the wrap block counts into the new window (bad_cnt=1).
//  Descrambler (1+x^39+x^58): runs on every valid block in any state; bit i of payload (LSB first):
//   d[i] = s[i] ^ s[i-39] ^ s[i-58], s = scrambled stream incl. 58 bits kept from prior blocks.
//  Decode (LOCKED only; blocks in HUNT produce no output), ctrl type = descrambled byte 0:
//   data         -> emit held word (if any), held <= payload, last=0.
//   0x78 idle    -> no effect on held slot.
//   0x1E sep, N = byte1 (0..6), data in bytes 2..7:
//     N==0: held present -> emit held with last=1, keep=8'hFF; no held -> ignored (empty frame).
//     N>0 : emit held (last=0) if present; held <= bytes 2..7 shifted to byte 0, keep=(1<<N)-1, last=1.
//   0xE1 sep7    -> as sep with N=7, data bytes 1..7.
//   N>6 on 0x1E or unknown type -> held cleared without emission, frame_err=1 (held present or not).
//  Held slot with last=1 is always emitted the next cycle; a block arriving that cycle is processed
//   normally (its data takes the slot after the flush). At most one axi word per cycle.
//  Latency: a data block's word appears 1 cycle after the next non-idle block arrives;
//   sep-carried tail appears 2 cycles after sep arrival (held-word at +1, tail at +2).
//  Plain data words: keep=8'hFF.
//  Lock loss with held slot non-empty -> slot cleared, frame_err=1 same cycle as rx_aligned falls.
//  rst mid-frame: everything to reset values immediately; no frame_err.
// TESTING
//  1. 64 blocks hdr 01 after reset -> rx_aligned=1 on cycle after 64th; 63 then hdr 00 -> slip pulse, no lock.
//  2. Locked; scrambled data D0,D1 then 0x1E N=0 -> D0 (last=0), D1 (last=1, keep=FF), data matches TX.
//  3. Data D0, idle x3, 0x1E N=3 bytes AA BB CC -> D0 last=0, then 64'h..CCBBAA keep=8'h07 last=1.
//  4. Data, 0x1E N=7 -> held discarded, frame_err pulse, no axi_valid; next frame decodes cleanly.
//  5. Locked mid-frame, 16 hdr 11 in one window -> rx_aligned=0, frame_err=1; 15 bad + wrap -> stays locked.
//  6. 0xE1 alone (no held) -> one word keep=8'h7F last=1; assert rst mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/aurora_rx_lane_if.sv
// Receive-lane bus: encoded blocks in from the gearbox, slip request back,
// decoded AXI-stream words and status out. dbg_state mirrors the lock FSM.
interface aurora_rx_lane_if #(
    parameter int AXI_DATA_SIZE     = 64,
    parameter int ENCODED_DATA_SIZE = 66
);
    // Handshake: encoded_valid and axi_valid are qualifiers only. There is no
    // ready in either direction; a block or word is consumed/presented in the
    // cycle its valid is high, and the receiver must always accept it.
    logic                         encoded_valid;
    logic [ENCODED_DATA_SIZE-1:0] encoded_data;
    logic                         slip;
    logic                         rx_aligned;
    logic                         axi_valid;
    logic                         axi_last;
    logic [AXI_DATA_SIZE/8-1:0]   axi_keep;
    logic [AXI_DATA_SIZE-1:0]     axi_data;
    logic                         frame_err;
    logic                         dbg_state;

    modport master (
        input  encoded_valid, encoded_data,
        output slip, rx_aligned, axi_valid, axi_last, axi_keep, axi_data,
        output frame_err, dbg_state
    );

    modport slave (
        output encoded_valid, encoded_data,
        input  slip, rx_aligned, axi_valid, axi_last, axi_keep, axi_data,
        input  frame_err, dbg_state
    );
endinterface

// File: rtl/aurora_rx_lane.sv
// 64B/66B receive lane: block lock with slip requests, x^58+x^39+1
// self-sync descrambler, control-block decode into AXI-stream words.
module aurora_rx_lane #(
    parameter int AXI_DATA_SIZE     = 64,
    parameter int ENCODED_DATA_SIZE = 66,
    parameter int LOCK_COUNT        = 64,
    parameter int BAD_LIMIT         = 16
) (
    input  logic              clk,
    input  logic              rst,
    aurora_rx_lane_if.master  bus
);
    localparam int PAY_W  = AXI_DATA_SIZE;
    localparam int KEEP_W = AXI_DATA_SIZE / 8;
    localparam int SCR_W  = 58;
    localparam int WIN_W  = 6;
    localparam int GOOD_W = $clog2(LOCK_COUNT);
    localparam int BAD_W  = $clog2(BAD_LIMIT);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = '1;

    localparam logic [7:0] T_IDLE = 8'h78;
    localparam logic [7:0] T_SEP  = 8'h1E;
    localparam logic [7:0] T_SEP7 = 8'hE1;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [1:0]          skip_q, skip_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic                slip_q, slip_d;
    logic                drop;

    logic [SCR_W-1:0]    scr_q, scr_d;
    logic [PAY_W-1:0]    desc;
    logic [PAY_W+SCR_W-1:0] ext;

    logic                held_valid_q, held_valid_d;
    logic                held_last_q, held_last_d;
    logic [KEEP_W-1:0]   held_keep_q, held_keep_d;
    logic [PAY_W-1:0]    held_data_q, held_data_d;

    logic                axi_valid_q, axi_valid_d;
    logic                axi_last_q, axi_last_d;
    logic [KEEP_W-1:0]   axi_keep_q, axi_keep_d;
    logic [PAY_W-1:0]    axi_data_q, axi_data_d;
    logic                frame_err_q, frame_err_d;

    logic [1:0]          hdr;
    logic [PAY_W-1:0]    payload;
    logic                hdr_ok;
    logic                is_data;
    logic [7:0]          ctrl_type;
    logic [7:0]          ctrl_n;

    assign hdr       = bus.encoded_data[ENCODED_DATA_SIZE-1 -: 2];
    assign payload   = bus.encoded_data[PAY_W-1:0];
    assign hdr_ok    = (hdr == 2'b01) || (hdr == 2'b10);
    assign is_data   = (hdr == 2'b01);
    assign ctrl_type = desc[7:0];
    assign ctrl_n    = desc[15:8];

    // State register: every flop of the lane, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            good_q       <= '0;
            skip_q       <= '0;
            win_q        <= '0;
            bad_q        <= '0;
            slip_q       <= 1'b0;
            scr_q        <= '0;
            held_valid_q <= 1'b0;
            held_last_q  <= 1'b0;
            held_keep_q  <= '0;
            held_data_q  <= '0;
            axi_valid_q  <= 1'b0;
            axi_last_q   <= 1'b0;
            axi_keep_q   <= '0;
            axi_data_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            skip_q       <= skip_d;
            win_q        <= win_d;
            bad_q        <= bad_d;
            slip_q       <= slip_d;
            scr_q        <= scr_d;
            held_valid_q <= held_valid_d;
            held_last_q  <= held_last_d;
            held_keep_q  <= held_keep_d;
            held_data_q  <= held_data_d;
            axi_valid_q  <= axi_valid_d;
            axi_last_q   <= axi_last_d;
            axi_keep_q   <= axi_keep_d;
            axi_data_q   <= axi_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Lock FSM next state: header hunt with slip, then windowed bad-header count.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        skip_d  = skip_q;
        win_d   = win_q;
        bad_d   = bad_q;
        slip_d  = 1'b0;
        drop    = 1'b0;
        if (bus.encoded_valid) begin
            case (state_q)
                HUNT: begin
                    if (skip_q != 2'd0) begin
                        // Blocks still in flight from the old alignment are ignored.
                        skip_d = skip_q - 2'd1;
                    end else if (hdr_ok) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            win_d   = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                        slip_d = 1'b1;
                        skip_d = 2'd2;
                    end
                end
                LOCKED: begin
                    if (win_q == WIN_LAST) begin
                        // Wrap block opens the new window; its own header counts there.
                        win_d = '0;
                        bad_d = hdr_ok ? '0 : BAD_W'(1);
                    end else begin
                        win_d = win_q + 1'b1;
                        if (!hdr_ok) begin
                            if (bad_q == BAD_LAST) begin
                                state_d = HUNT;
                                good_d  = '0;
                                skip_d  = '0;
                                win_d   = '0;
                                bad_d   = '0;
                                drop    = 1'b1;
                            end else begin
                                bad_d = bad_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Self-synchronising descrambler; ext[58+i] is payload bit i, ext[57] the newest old bit.
    always_comb begin
        ext = {payload, scr_q};
        for (int i = 0; i < PAY_W; i++) begin
            desc[i] = ext[i + SCR_W] ^ ext[i + SCR_W - 39] ^ ext[i];
        end
        scr_d = bus.encoded_valid ? payload[PAY_W-1 -: SCR_W] : scr_q;
    end

    // Decode: flush a finished tail first, then let the current block use the slot.
    always_comb begin
        held_valid_d = held_valid_q;
        held_last_d  = held_last_q;
        held_keep_d  = held_keep_q;
        held_data_d  = held_data_q;
        axi_valid_d  = 1'b0;
        axi_last_d   = 1'b0;
        axi_keep_d   = '0;
        axi_data_d   = '0;
        frame_err_d  = 1'b0;
        if (held_valid_q && held_last_q) begin
            axi_valid_d  = 1'b1;
            axi_last_d   = 1'b1;
            axi_keep_d   = held_keep_q;
            axi_data_d   = held_data_q;
            held_valid_d = 1'b0;
            held_last_d  = 1'b0;
        end
        if (drop) begin
            if (held_valid_d) frame_err_d = 1'b1;
            held_valid_d = 1'b0;
            held_last_d  = 1'b0;
        end else if (bus.encoded_valid && state_q == LOCKED && hdr_ok) begin
            if (is_data) begin
                if (held_valid_d) begin
                    axi_valid_d = 1'b1;
                    axi_keep_d  = held_keep_q;
                    axi_data_d  = held_data_q;
                end
                held_valid_d = 1'b1;
                held_last_d  = 1'b0;
                held_keep_d  = '1;
                held_data_d  = desc;
            end else begin
                case (ctrl_type)
                    T_IDLE: ;
                    T_SEP: begin
                        if (ctrl_n == 8'd0) begin
                            // Terminator with no tail bytes closes the held word.
                            if (held_valid_d) begin
                                axi_valid_d  = 1'b1;
                                axi_last_d   = 1'b1;
                                axi_keep_d   = '1;
                                axi_data_d   = held_data_q;
                                held_valid_d = 1'b0;
                            end
                        end else if (ctrl_n <= 8'd6) begin
                            if (held_valid_d) begin
                                axi_valid_d = 1'b1;
                                axi_keep_d  = held_keep_q;
                                axi_data_d  = held_data_q;
                            end
                            held_valid_d = 1'b1;
                            held_last_d  = 1'b1;
                            held_keep_d  = ~(8'hFF << ctrl_n[2:0]);
                            held_data_d  = desc >> 16;
                        end else begin
                            held_valid_d = 1'b0;
                            held_last_d  = 1'b0;
                            frame_err_d  = 1'b1;
                        end
                    end
                    T_SEP7: begin
                        if (held_valid_d) begin
                            axi_valid_d = 1'b1;
                            axi_keep_d  = held_keep_q;
                            axi_data_d  = held_data_q;
                        end
                        held_valid_d = 1'b1;
                        held_last_d  = 1'b1;
                        held_keep_d  = 8'h7F;
                        held_data_d  = desc >> 8;
                    end
                    default: begin
                        held_valid_d = 1'b0;
                        held_last_d  = 1'b0;
                        frame_err_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // Outputs: straight from registers, rx_aligned follows the registered state.
    always_comb begin
        bus.slip       = slip_q;
        bus.rx_aligned = (state_q == LOCKED);
        bus.axi_valid  = axi_valid_q;
        bus.axi_last   = axi_last_q;
        bus.axi_keep   = axi_keep_q;
        bus.axi_data   = axi_data_q;
        bus.frame_err  = frame_err_q;
        bus.dbg_state  = state_q;
    end
endmodule

// File: tb/tb_aurora_rx_lane.sv
// Bench for aurora_rx_lane: a bit-serial scrambler model feeds plaintext
// frames in, and the expected AXI words come from the frame contents.
module tb_aurora_rx_lane;
    localparam int LOCK_COUNT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aurora_rx_lane_if bus ();
    aurora_rx_lane dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_edge;
    bit hist[$];
    logic [72:0] exp_q[$];
    logic [72:0] obs_q[$];
    int exp_edge[$];
    int obs_edge[$];
    int ferr_edges[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every emitted word and frame_err pulse with its edge number.
    always @(negedge clk) begin
        if (bus.axi_valid) begin
            obs_q.push_back({bus.axi_last, bus.axi_keep, bus.axi_data});
            obs_edge.push_back(cyc);
        end
        if (bus.frame_err) ferr_edges.push_back(cyc);
    end

    // Transmit scrambler: s[i] = d[i] ^ s[i-39] ^ s[i-58] over the serial stream.
    function automatic logic [63:0] scramble(input logic [63:0] d);
        logic [63:0] s;
        for (int i = 0; i < 64; i++) begin
            s[i] = d[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
            hist.push_back(s[i]);
            void'(hist.pop_front());
        end
        return s;
    endfunction

    task automatic clear_model();
        hist.delete();
        repeat (58) hist.push_back(1'b0);
        exp_q.delete(); exp_edge.delete();
        obs_q.delete(); obs_edge.delete(); ferr_edges.delete();
    endtask

    task automatic apply_reset();
        bus.encoded_valid = 1'b0;
        bus.encoded_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic send_block(input logic [1:0] hdr, input logic [63:0] plain);
        logic [63:0] s;
        @(negedge clk);
        s = scramble(plain);
        bus.encoded_valid = 1'b1;
        bus.encoded_data  = {hdr, s};
        @(posedge clk);
        #1;
        bus.encoded_valid = 1'b0;
        last_edge = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lock_up();
        repeat (LOCK_COUNT) send_block(2'b10, 64'h78);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.encoded_valid = 1'b0;
        bus.encoded_data  = '0;
        gap(2);
        n_checks++;
        if ({bus.slip, bus.rx_aligned, bus.frame_err, bus.dbg_state} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_status: slip/aligned/ferr/state=%b required 0000",
                     {bus.slip, bus.rx_aligned, bus.frame_err, bus.dbg_state});
        end
        n_checks++;
        if ({bus.axi_valid, bus.axi_last, bus.axi_keep, bus.axi_data} !== 74'b0) begin
            n_fail++;
            $display("FAIL reset_axi: valid=%b last=%b keep=%h data=%h required all 0",
                     bus.axi_valid, bus.axi_last, bus.axi_keep, bus.axi_data);
        end
        apply_reset();
    endtask

    task automatic test_lock();
        apply_reset();
        repeat (LOCK_COUNT - 1) send_block(2'b01, {$urandom, $urandom});
        n_checks++;
        if (bus.rx_aligned !== 1'b0) begin
            n_fail++; $display("FAIL lock_63: rx_aligned=%b required 0", bus.rx_aligned);
        end
        send_block(2'b01, {$urandom, $urandom});
        n_checks++;
        if (bus.rx_aligned !== 1'b1) begin
            n_fail++; $display("FAIL lock_64: rx_aligned=%b required 1", bus.rx_aligned);
        end

        apply_reset();
        repeat (LOCK_COUNT - 1) send_block(2'b10, 64'h78);
        send_block(2'b00, {$urandom, $urandom});
        n_checks++;
        if ({bus.slip, bus.rx_aligned} !== 2'b10) begin
            n_fail++; $display("FAIL slip_pulse: slip,aligned=%b required 10", {bus.slip, bus.rx_aligned});
        end
        gap(1);
        n_checks++;
        if (bus.slip !== 1'b0) begin
            n_fail++; $display("FAIL slip_width: slip=%b required 0", bus.slip);
        end
        for (int k = 0; k < 2; k++) begin
            send_block(2'b11, {$urandom, $urandom});
            n_checks++;
            if (bus.slip !== 1'b0) begin
                n_fail++; $display("FAIL slip_skip%0d: slip=%b required 0", k, bus.slip);
            end
        end
        send_block(2'b00, {$urandom, $urandom});
        n_checks++;
        if (bus.slip !== 1'b1) begin
            n_fail++; $display("FAIL slip_again: slip=%b required 1", bus.slip);
        end
        repeat (LOCK_COUNT + 1) send_block(2'b01, {$urandom, $urandom});
        n_checks++;
        if (bus.rx_aligned !== 1'b0) begin
            n_fail++; $display("FAIL relock_early: rx_aligned=%b required 0", bus.rx_aligned);
        end
        send_block(2'b01, {$urandom, $urandom});
        n_checks++;
        if (bus.rx_aligned !== 1'b1 || bus.dbg_state !== 1'b1) begin
            n_fail++; $display("FAIL relock: rx_aligned=%b state=%b required 1/1", bus.rx_aligned, bus.dbg_state);
        end
    endtask

    task automatic test_data_frame();
        logic [63:0] d0, d1;
        apply_reset();
        lock_up();
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        send_block(2'b01, d0);
        send_block(2'b01, d1);
        exp_q.push_back({1'b0, 8'hFF, d0}); exp_edge.push_back(last_edge);
        send_block(2'b10, 64'h1E);
        exp_q.push_back({1'b1, 8'hFF, d1}); exp_edge.push_back(last_edge);
        gap(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL frame_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i] || obs_edge[i] != exp_edge[i]) begin
                n_fail++;
                $display("FAIL frame_word%0d: got %h @%0d required %h @%0d", i, obs_q[i], obs_edge[i], exp_q[i], exp_edge[i]);
            end
        end
    endtask

    task automatic test_short_tail();
        logic [63:0] d0;
        apply_reset();
        lock_up();
        d0 = {$urandom, $urandom};
        send_block(2'b01, d0);
        repeat (3) send_block(2'b10, 64'h78);
        send_block(2'b10, {40'h0, 8'hCC, 8'hBB, 8'hAA, 8'h03, 8'h1E});
        exp_q.push_back({1'b0, 8'hFF, d0});         exp_edge.push_back(last_edge);
        exp_q.push_back({1'b1, 8'h07, 64'hCCBBAA}); exp_edge.push_back(last_edge + 1);
        gap(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL tail_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i] || obs_edge[i] != exp_edge[i]) begin
                n_fail++;
                $display("FAIL tail_word%0d: got %h @%0d required %h @%0d", i, obs_q[i], obs_edge[i], exp_q[i], exp_edge[i]);
            end
        end
    endtask

    task automatic test_bad_ctrl();
        logic [63:0] d2;
        apply_reset();
        lock_up();
        send_block(2'b01, {$urandom, $urandom});
        send_block(2'b10, {48'h0, 8'h07, 8'h1E});
        n_checks++;
        if ({bus.frame_err, bus.axi_valid} !== 2'b10) begin
            n_fail++; $display("FAIL sep_n7: ferr,valid=%b required 10", {bus.frame_err, bus.axi_valid});
        end
        gap(1);
        n_checks++;
        if (bus.frame_err !== 1'b0) begin
            n_fail++; $display("FAIL ferr_width: frame_err=%b required 0", bus.frame_err);
        end
        send_block(2'b10, {48'h0, 8'h00, 8'h55});
        n_checks++;
        if (bus.frame_err !== 1'b1) begin
            n_fail++; $display("FAIL unknown_type: frame_err=%b required 1", bus.frame_err);
        end
        d2 = {$urandom, $urandom};
        send_block(2'b01, d2);
        send_block(2'b10, 64'h1E);
        exp_q.push_back({1'b1, 8'hFF, d2});
        gap(3);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL after_err: got %0d words first %h required 1 word %h", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0] : 73'h0, exp_q[0]);
        end
        n_checks++;
        if (ferr_edges.size() != 2) begin
            n_fail++; $display("FAIL ferr_total: got %0d pulses required 2", ferr_edges.size());
        end
    endtask

    task automatic test_lock_loss();
        apply_reset();
        lock_up();
        send_block(2'b01, {$urandom, $urandom});
        repeat (15) send_block(2'b11, {$urandom, $urandom});
        n_checks++;
        if ({bus.rx_aligned, bus.frame_err} !== 2'b10) begin
            n_fail++; $display("FAIL bad15: aligned,ferr=%b required 10", {bus.rx_aligned, bus.frame_err});
        end
        send_block(2'b11, {$urandom, $urandom});
        n_checks++;
        if ({bus.rx_aligned, bus.frame_err} !== 2'b01) begin
            n_fail++; $display("FAIL bad16: aligned,ferr=%b required 01", {bus.rx_aligned, bus.frame_err});
        end
        gap(2);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL lost_emit: got %0d words required 0", obs_q.size());
        end

        apply_reset();
        lock_up();
        repeat (48) send_block(2'b10, 64'h78);
        repeat (15) send_block(2'b11, {$urandom, $urandom});
        send_block(2'b00, {$urandom, $urandom});
        n_checks++;
        if (bus.rx_aligned !== 1'b1) begin
            n_fail++; $display("FAIL wrap_keep: rx_aligned=%b required 1", bus.rx_aligned);
        end
        repeat (14) send_block(2'b11, {$urandom, $urandom});
        n_checks++;
        if (bus.rx_aligned !== 1'b1) begin
            n_fail++; $display("FAIL wrap_new15: rx_aligned=%b required 1", bus.rx_aligned);
        end
        send_block(2'b11, {$urandom, $urandom});
        n_checks++;
        if ({bus.rx_aligned, bus.frame_err} !== 2'b00) begin
            n_fail++; $display("FAIL wrap_new16: aligned,ferr=%b required 00", {bus.rx_aligned, bus.frame_err});
        end
    endtask

    task automatic test_sep7_and_reset();
        logic [55:0] b;
        apply_reset();
        lock_up();
        b = {$urandom, $urandom};
        send_block(2'b10, {b, 8'hE1});
        exp_q.push_back({1'b1, 8'h7F, {8'h00, b}}); exp_edge.push_back(last_edge + 1);
        gap(2);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_edge[0] != exp_edge[0]) begin
            n_fail++;
            $display("FAIL sep7: got %0d words first %h required %h @%0d", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0] : 73'h0, exp_q[0], exp_edge[0]);
        end
        send_block(2'b01, {$urandom, $urandom});
        send_block(2'b01, {$urandom, $urandom});
        n_checks++;
        if (bus.axi_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_valid: axi_valid=%b required 1", bus.axi_valid);
        end
        ferr_edges.delete();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.axi_valid, bus.axi_last, bus.axi_keep, bus.axi_data, bus.slip, bus.frame_err} !== 76'b0) begin
            n_fail++;
            $display("FAIL async_rst_axi: valid=%b last=%b keep=%h data=%h slip=%b ferr=%b required 0",
                     bus.axi_valid, bus.axi_last, bus.axi_keep, bus.axi_data, bus.slip, bus.frame_err);
        end
        n_checks++;
        if (bus.rx_aligned !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_aligned: rx_aligned=%b required 0", bus.rx_aligned);
        end
        gap(2);
        rst = 1'b0;
        hist.delete();
        repeat (58) hist.push_back(1'b0);
        gap(3);
        n_checks++;
        if (ferr_edges.size() != 0 || bus.rx_aligned !== 1'b0) begin
            n_fail++; $display("FAIL post_rst: ferr pulses=%0d aligned=%b required 0/0", ferr_edges.size(), bus.rx_aligned);
        end
    endtask

    task automatic test_random_frames();
        logic [63:0] d, tb;
        int nd, nt;
        apply_reset();
        lock_up();
        for (int f = 0; f < 40; f++) begin
            nd = $urandom_range(0, 4);
            nt = $urandom_range(0, 7);
            if (nt == 0 && nd == 0) nd = 1;
            for (int w = 0; w < nd; w++) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 1) == 1) send_block(2'b10, 64'h78);
                    else gap(1);
                end
                d = {$urandom, $urandom};
                send_block(2'b01, d);
                exp_q.push_back({(nt == 0 && w == nd - 1) ? 1'b1 : 1'b0, 8'hFF, d});
            end
            tb = {$urandom, $urandom};
            if (nt == 0) begin
                send_block(2'b10, 64'h1E);
            end else if (nt == 7) begin
                tb[63:56] = 8'h00;
                send_block(2'b10, {tb[55:0], 8'hE1});
                exp_q.push_back({1'b1, 8'h7F, tb});
            end else begin
                tb = tb & ((64'h1 << (8 * nt)) - 64'h1);
                send_block(2'b10, {tb[47:0], 8'(nt), 8'h1E});
                exp_q.push_back({1'b1, 8'((1 << nt) - 1), tb});
            end
        end
        gap(4);
        n_checks++;
        if (obs_q.size() != exp_q.size() || ferr_edges.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d words %0d errs required %0d words 0 errs",
                     obs_q.size(), ferr_edges.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.encoded_valid = 1'b0;
        bus.encoded_data  = '0;
        test_reset();
        test_lock();
        test_data_frame();
        test_short_tail();
        test_bad_ctrl();
        test_lock_loss();
        test_sep7_and_reset();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
